// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: EX bundle layout, memory size codes and stage payload types
package mem_wb_stage_pkg;
  localparam int EX_DATA = 107;
  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;
  typedef struct packed {
    logic        mem_unsigned;
    logic [1:0]  mem_size;
    logic        mem_we;
    logic        mem_re;
    logic        rf_we;
    logic [4:0]  rd;
    logic [31:0] store_data;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } ex_t;
  typedef struct packed {
    logic        mem_unsigned;
    logic [1:0]  mem_size;
    logic        mem_re;
    logic        rf_we;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } w_t;
  localparam int MEM_DATA = $bits(w_t);
endpackage

// File: rtl/mem_wb_stage_align.sv
// mem_align: store strobe/data lane placement and load extraction with extension
module mem_align
  import mem_wb_stage_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr,
  input  logic [31:0] store_data,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_value
);
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  always_comb begin
    wstrb = st_size == MEM_SIZE_B ? 4'b0001 << st_addr :
            st_size == MEM_SIZE_H ? 4'b0011 << st_addr : 4'b1111;
    wdata = st_size == MEM_SIZE_B ? {4{store_data[7:0]}} :
            st_size == MEM_SIZE_H ? {2{store_data[15:0]}} : store_data;
    ld_b = rdata[{ld_addr, 3'b000} +: 8];
    ld_h = ld_addr[1] ? rdata[31:16] : rdata[15:0];
    load_value = ld_size == MEM_SIZE_B ? {{24{~ld_unsigned & ld_b[7]}}, ld_b} :
                 ld_size == MEM_SIZE_H ? {{16{~ld_unsigned & ld_h[15]}}, ld_h} : rdata;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: EX/MEM and MEM/WB registers with split-transaction data memory access
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_to_mem_reg_valid,
  input  logic [EX_DATA-1:0] ex_data,
  output logic               ex_mem_reg_allow_in,
  output logic               data_req,
  output logic               data_wr,
  output logic [3:0]         data_wstrb,
  output logic [31:0]        data_addr,
  output logic [31:0]        data_wdata,
  input  logic               data_addr_ok,
  input  logic               data_data_ok,
  input  logic [31:0]        data_rdata,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_wdata,
  output logic               wb_we,
  output logic [31:0]        debug_wb_pc
);
  ex_t         m;
  w_t          w;
  logic        m_valid;
  logic        w_valid;
  logic        w_pending;
  logic        m_is_mem;
  logic        m_ready_go;
  logic        w_ready_go;
  logic        w_allow_in;
  logic        m_to_w;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_value;
  mem_align u_align (
    .st_size    (m.mem_size),
    .st_addr    (m.alu_result[1:0]),
    .store_data (m.store_data),
    .ld_size    (w.mem_size),
    .ld_unsigned(w.mem_unsigned),
    .ld_addr    (w.alu_result[1:0]),
    .rdata      (data_rdata),
    .wstrb      (st_wstrb),
    .wdata      (data_wdata),
    .load_value (ld_value)
  );
  always_comb begin
    m_is_mem = m.mem_re | m.mem_we;
    data_req = m_valid && m_is_mem && !w_pending;
    data_wr = data_req && m.mem_we;
    data_wstrb = data_wr ? st_wstrb : 4'b0000;
    data_addr = {m.alu_result[31:2], 2'b00};
    m_ready_go = !m_is_mem || (data_req && data_addr_ok);
    w_ready_go = !w_pending || data_data_ok;
    w_allow_in = !w_valid || w_ready_go;
    m_to_w = m_valid && m_ready_go && w_allow_in;
    ex_mem_reg_allow_in = !m_valid || (m_ready_go && w_allow_in);
    wb_we = w_valid && w_ready_go && w.rf_we && (w.rd != 5'd0);
    wb_rd = wb_we ? w.rd : 5'd0;
    wb_wdata = wb_we ? (w.mem_re ? ld_value : w.alu_result) : 32'd0;
    debug_wb_pc = wb_we ? w.pc : 32'd0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      w_valid <= 1'b0;
      w_pending <= 1'b0;
      m <= '0;
      w <= '0;
    end else begin
      if (ex_mem_reg_allow_in) m_valid <= ex_to_mem_reg_valid;
      if (ex_mem_reg_allow_in && ex_to_mem_reg_valid) m <= ex_data;
      if (m_to_w) begin
        w_valid <= 1'b1;
        w_pending <= m_is_mem;
        w <= {m.mem_unsigned, m.mem_size, m.mem_re, m.rf_we, m.rd, m.alu_result, m.pc};
      end else if (w_ready_go) begin
        w_valid <= 1'b0;
        w_pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed table and corner sequences for mem_wb_stage
module tb_mem_wb_stage;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ex_to_mem_reg_valid = 1'b0;
  logic [106:0] ex_data = '0;
  logic         ex_mem_reg_allow_in;
  logic         data_req;
  logic         data_wr;
  logic [3:0]   data_wstrb;
  logic [31:0]  data_addr;
  logic [31:0]  data_wdata;
  logic         data_addr_ok = 1'b1;
  logic         data_data_ok = 1'b0;
  logic [31:0]  data_rdata = '0;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_wdata;
  logic         wb_we;
  logic [31:0]  debug_wb_pc;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [106:0] ex;
    logic [31:0]  rdata;
    logic         e_req;
    logic         e_wr;
    logic [31:0]  e_addr;
    logic [3:0]   e_wstrb;
    logic [31:0]  e_wdata;
    logic         e_we;
    logic [4:0]   e_rd;
    logic [31:0]  e_wd;
    logic [31:0]  e_pc;
  } vec_t;
  vec_t v[13];
  mem_wb_stage dut (
    .clk                (clk),
    .reset              (reset),
    .ex_to_mem_reg_valid(ex_to_mem_reg_valid),
    .ex_data            (ex_data),
    .ex_mem_reg_allow_in(ex_mem_reg_allow_in),
    .data_req           (data_req),
    .data_wr            (data_wr),
    .data_wstrb         (data_wstrb),
    .data_addr          (data_addr),
    .data_wdata         (data_wdata),
    .data_addr_ok       (data_addr_ok),
    .data_data_ok       (data_data_ok),
    .data_rdata         (data_rdata),
    .wb_rd              (wb_rd),
    .wb_wdata           (wb_wdata),
    .wb_we              (wb_we),
    .debug_wb_pc        (debug_wb_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [106:0] mk(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                                      input logic [4:0] rd, input logic rf_we, input logic re, input logic we,
                                      input logic [1:0] sz, input logic uns);
    return {uns, sz, we, re, rf_we, rd, sd, alu, pc};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, " allow_in"}, ex_mem_reg_allow_in, 1);
    chk({tag, " data_req"}, data_req, 0);
    chk({tag, " data_wr"}, data_wr, 0);
    chk({tag, " wstrb"}, data_wstrb, 0);
    chk({tag, " wb_we"}, wb_we, 0);
    chk({tag, " wb_rd"}, wb_rd, 0);
    chk({tag, " wb_wdata"}, wb_wdata, 0);
    chk({tag, " debug_pc"}, debug_wb_pc, 0);
  endtask
  initial begin
    v[0]  = '{mk(32'h1000, 32'h1234, 0, 5, 1, 0, 0, 2'b10, 0), 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234, 32'h1000};
    v[1]  = '{mk(32'h1004, 32'h0777, 0, 0, 1, 0, 0, 2'b10, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[2]  = '{mk(32'h1008, 32'h0888, 0, 3, 0, 0, 0, 2'b10, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[3]  = '{mk(32'h100c, 32'h0103, 0, 7, 1, 1, 0, 2'b00, 0), 32'h80FF_7F01, 1, 0, 32'h100, 0, 0, 1, 7, 32'hFFFF_FF80, 32'h100c};
    v[4]  = '{mk(32'h1010, 32'h0102, 0, 7, 1, 1, 0, 2'b00, 1), 32'h80FF_7F01, 1, 0, 32'h100, 0, 0, 1, 7, 32'h0000_00FF, 32'h1010};
    v[5]  = '{mk(32'h1014, 32'h0102, 0, 11, 1, 1, 0, 2'b01, 1), 32'h8001_0000, 1, 0, 32'h100, 0, 0, 1, 11, 32'h0000_8001, 32'h1014};
    v[6]  = '{mk(32'h1018, 32'h0102, 0, 12, 1, 1, 0, 2'b01, 0), 32'h8001_0000, 1, 0, 32'h100, 0, 0, 1, 12, 32'hFFFF_8001, 32'h1018};
    v[7]  = '{mk(32'h101c, 32'h0100, 0, 13, 1, 1, 0, 2'b01, 0), 32'h8001_7FFE, 1, 0, 32'h100, 0, 0, 1, 13, 32'h0000_7FFE, 32'h101c};
    v[8]  = '{mk(32'h1020, 32'h0204, 0, 31, 1, 1, 0, 2'b10, 0), 32'hDEAD_BEEF, 1, 0, 32'h204, 0, 0, 1, 31, 32'hDEAD_BEEF, 32'h1020};
    v[9]  = '{mk(32'h1024, 32'h0202, 32'hABCD_1234, 0, 0, 0, 1, 2'b01, 0), 0, 1, 1, 32'h200, 4'b1100, 32'h1234_1234, 0, 0, 0, 0};
    v[10] = '{mk(32'h1028, 32'h0301, 32'h0000_00A5, 0, 0, 0, 1, 2'b00, 0), 0, 1, 1, 32'h300, 4'b0010, 32'hA5A5_A5A5, 0, 0, 0, 0};
    v[11] = '{mk(32'h102c, 32'h0300, 32'hCAFE_F00D, 0, 0, 0, 1, 2'b10, 0), 0, 1, 1, 32'h300, 4'b1111, 32'hCAFE_F00D, 0, 0, 0, 0};
    v[12] = '{mk(32'h1030, 32'h0303, 32'h0000_5678, 0, 0, 0, 1, 2'b01, 0), 0, 1, 1, 32'h300, 4'b1000, 32'h5678_5678, 0, 0, 0, 0};
    @(negedge clk);
    chk_idle("reset_held");
    @(negedge clk);
    reset = 1'b0;
    #1 chk_idle("after_reset");
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      data_data_ok = 1'b0;
      ex_to_mem_reg_valid = 1'b1;
      ex_data = v[i].ex;
      #1 chk($sformatf("v%0d allow_in", i), ex_mem_reg_allow_in, 1);
      @(negedge clk);
      ex_to_mem_reg_valid = 1'b0;
      #1 chk($sformatf("v%0d data_req", i), data_req, v[i].e_req);
      if (v[i].e_req) begin
        chk($sformatf("v%0d data_wr", i), data_wr, v[i].e_wr);
        chk($sformatf("v%0d data_addr", i), data_addr, v[i].e_addr);
        chk($sformatf("v%0d wstrb", i), data_wstrb, v[i].e_wstrb);
        if (v[i].e_wr) chk($sformatf("v%0d wdata", i), data_wdata, v[i].e_wdata);
      end
      @(negedge clk);
      if (v[i].e_req) begin
        data_data_ok = 1'b1;
        data_rdata = v[i].rdata;
      end
      #1;
      chk($sformatf("v%0d wb_we", i), wb_we, v[i].e_we);
      chk($sformatf("v%0d wb_rd", i), wb_rd, v[i].e_rd);
      chk($sformatf("v%0d wb_wdata", i), wb_wdata, v[i].e_wd);
      chk($sformatf("v%0d debug_pc", i), debug_wb_pc, v[i].e_pc);
    end
    @(negedge clk);
    data_data_ok = 1'b0;
    ex_to_mem_reg_valid = 1'b1;
    ex_data = mk(32'h2000, 32'h0103, 0, 8, 1, 1, 0, 2'b00, 0);
    @(negedge clk);
    ex_data = mk(32'h2004, 32'h0055, 0, 9, 1, 0, 0, 2'b10, 0);
    #1 chk("lb_seq accept allow_in", ex_mem_reg_allow_in, 1);
    @(negedge clk);
    ex_to_mem_reg_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 chk($sformatf("lb_seq hold%0d allow_in", k), ex_mem_reg_allow_in, 0);
      chk($sformatf("lb_seq hold%0d wb_we", k), wb_we, 0);
      @(negedge clk);
    end
    data_data_ok = 1'b1;
    data_rdata = 32'h80FF_7F01;
    #1 chk("lb_seq wb_we", wb_we, 1);
    chk("lb_seq wb_rd", wb_rd, 8);
    chk("lb_seq wb_wdata", wb_wdata, 32'hFFFF_FF80);
    chk("lb_seq release allow_in", ex_mem_reg_allow_in, 1);
    @(negedge clk);
    data_data_ok = 1'b0;
    #1 chk("lb_seq add wb_we", wb_we, 1);
    chk("lb_seq add wb_rd", wb_rd, 9);
    chk("lb_seq add wb_wdata", wb_wdata, 32'h55);
    chk("lb_seq add debug_pc", debug_wb_pc, 32'h2004);
    @(negedge clk);
    data_addr_ok = 1'b0;
    ex_to_mem_reg_valid = 1'b1;
    ex_data = mk(32'h3000, 32'h0400, 32'h0000_0099, 10, 1, 1, 0, 2'b10, 0);
    @(negedge clk);
    ex_data = mk(32'h3004, 32'h0066, 0, 14, 1, 0, 0, 2'b10, 0);
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("lw_stall%0d data_req", k), data_req, 1);
      chk($sformatf("lw_stall%0d data_addr", k), data_addr, 32'h400);
      chk($sformatf("lw_stall%0d wdata", k), data_wdata, 32'h99);
      chk($sformatf("lw_stall%0d allow_in", k), ex_mem_reg_allow_in, 0);
      @(negedge clk);
    end
    data_addr_ok = 1'b1;
    #1 chk("lw_stall accept data_req", data_req, 1);
    chk("lw_stall accept data_addr", data_addr, 32'h400);
    chk("lw_stall accept allow_in", ex_mem_reg_allow_in, 1);
    @(negedge clk);
    ex_to_mem_reg_valid = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = 32'h1122_3344;
    #1 chk("lw_stall wb_wdata", wb_wdata, 32'h1122_3344);
    chk("lw_stall wb_rd", wb_rd, 10);
    @(negedge clk);
    data_data_ok = 1'b0;
    #1 chk("lw_stall add wb_rd", wb_rd, 14);
    chk("lw_stall add wb_wdata", wb_wdata, 32'h66);
    @(negedge clk);
    ex_to_mem_reg_valid = 1'b1;
    ex_data = mk(32'h4000, 32'h0500, 0, 6, 1, 1, 0, 2'b10, 0);
    @(negedge clk);
    ex_to_mem_reg_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 chk_idle("rst_pending");
    @(negedge clk);
    reset = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = 32'h1234_5678;
    #1 chk_idle("stray_ok");
    @(negedge clk);
    data_data_ok = 1'b0;
    #1 chk_idle("post_stray");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
